// File: rtl/escape_capture_bank.sv
// First-hit capture bank: each channel latches the shared counter on its first hit, then drains one word per transfer.
// Optional feature: define LIMIT_SAT_EN to force-capture unflagged channels once count >= limit.
module escape_capture_bank #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 24,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clr,
  input  logic [NUM_CH-1:0] hit,
  input  logic [DATA_W-1:0] count,
  input  logic [DATA_W-1:0] limit,
  output logic [NUM_CH-1:0] flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_escaped,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [NUM_CH-1:0] r_flags;
  logic [NUM_CH-1:0] r_esc;
  logic [DATA_W-1:0] r_data [NUM_CH];
  logic [CH_W-1:0]   r_ptr;
  logic [DATA_W-1:0] r_outData;
  logic              r_outEsc;

  logic              w_sat;
  logic              w_allFlagged;
  logic              w_xfer;
  logic              w_lastXfer;
  logic              w_loadFirst;
  logic [CH_W-1:0]   w_ptrNext;

`ifdef LIMIT_SAT_EN
  assign w_sat = (r_state == S_CAPTURE) && (count >= limit);
`else
  // Saturation is compiled out, so channels complete only through hit.
  logic w_unusedLimit;
  assign w_unusedLimit = ^limit;
  assign w_sat         = 1'b0;
`endif

  assign w_allFlagged = &r_flags;
  assign w_xfer       = (r_state == S_DRAIN) && out_ready;
  assign w_lastXfer   = w_xfer && (r_ptr == LAST_CH);
  assign w_loadFirst  = (r_state == S_CAPTURE) && w_allFlagged;
  assign w_ptrNext    = r_ptr + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (clr) begin
      w_nextState = S_CAPTURE;
    end else begin
      case (r_state)
        S_IDLE:    w_nextState = S_IDLE;
        S_CAPTURE: if (w_allFlagged) w_nextState = S_DRAIN;
        S_DRAIN:   if (w_lastXfer) w_nextState = S_DONE;
        S_DONE:    w_nextState = S_DONE;
        default:   w_nextState = S_IDLE;
      endcase
    end
  end

  // A flagged channel is frozen: later hits or saturation never touch its data or escape bit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_flags <= '0;
      r_esc   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_data[i] <= '0;
      end
    end else if (clr) begin
      r_flags <= '0;
    end else if (r_state == S_CAPTURE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!r_flags[i] && (hit[i] || w_sat)) begin
          r_data[i]  <= count;
          r_esc[i]   <= hit[i];
          r_flags[i] <= 1'b1;
        end
      end
    end
  end

  // The first word is preloaded on the edge that enters DRAIN so out_valid never shows stale data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ptr     <= '0;
      r_outData <= '0;
      r_outEsc  <= 1'b0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (w_loadFirst) begin
      r_ptr     <= '0;
      r_outData <= r_data[0];
      r_outEsc  <= r_esc[0];
    end else if (w_xfer && !w_lastXfer) begin
      r_ptr     <= w_ptrNext;
      r_outData <= r_data[w_ptrNext];
      r_outEsc  <= r_esc[w_ptrNext];
    end
  end

  assign flags       = r_flags;
  assign out_valid   = (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign out_data    = r_outData;
  assign out_ch      = r_ptr;
  assign out_escaped = r_outEsc;

endmodule
